pir_sensor_conditioner: RTL

//  Front-end stage feeding the motion-alarm controller.
//  - Takes three raw asynchronous PIR sensor lines; synchronises, glitch-filters, pulse-stretches and blanks each one.
//  - Outputs one clean motion level per sensor (pir_out[i] drives pir_sensor_<i+1> of the alarm FSM).
//  - Holds all outputs low during sensor warm-up after enable.

---
 rtl/pir_pkg.sv | 10 +
 rtl/pir_channel_filter.sv | 104 ++++++++++
 rtl/pir_sensor_conditioner.sv | 66 ++++++
 3 files changed

// File: rtl/pir_pkg.sv
// pir_pkg: shared channel count and one-hot channel FSM state encoding for the PIR conditioner.
package pir_pkg;
  localparam int NUM_PIR = 3;
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_QUAL   = 4'b0010,
    ST_ACTIVE = 4'b0100,
    ST_BLANK  = 4'b1000
  } pir_state_e;
endpackage

// File: rtl/pir_channel_filter.sv
// pir_channel_filter: synchroniser, glitch qualifier, hold stretcher and blanking for one PIR line.
// Optional per-channel event counter when PIR_EVENT_COUNT_EN is defined.
module pir_channel_filter
  import pir_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int QUAL_CYCLES  = 8,
  parameter int HOLD_CYCLES  = 20,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_warm_done,
  input  logic             i_sensor_raw,
`ifdef PIR_EVENT_COUNT_EN
  input  logic             i_clear_counts,
  output logic [CNT_W-1:0] o_event_count,
`endif
  output logic             o_pir,
  output logic             o_pir_nxt
);
  localparam int QW = $clog2(QUAL_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  logic [SYNC_STAGES-1:0] r_sync;
  pir_state_e r_state, w_state;
  logic [QW-1:0] r_qcnt, w_qcnt;
  logic [HW-1:0] r_hcnt, w_hcnt;
  logic [BW-1:0] r_bcnt, w_bcnt;
  logic r_pir;
  logic w_s;
  assign w_s       = r_sync[SYNC_STAGES-1];
  assign o_pir     = r_pir;
  assign o_pir_nxt = (w_state == ST_ACTIVE);
  always_comb begin
    w_state = r_state;
    w_qcnt  = r_qcnt;
    w_hcnt  = r_hcnt;
    w_bcnt  = r_bcnt;
    if (!i_enable) begin
      w_state = ST_IDLE;
      w_qcnt  = '0;
      w_hcnt  = '0;
      w_bcnt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_warm_done && w_s) begin
          w_state = (QUAL_CYCLES == 1) ? ST_ACTIVE : ST_QUAL;
          w_qcnt  = (QUAL_CYCLES == 1) ? '0 : QW'(1);
          w_hcnt  = '0;
        end
        ST_QUAL: if (!w_s) begin
          w_state = ST_IDLE;
          w_qcnt  = '0;
        end else if (r_qcnt == QW'(QUAL_CYCLES - 1)) begin
          w_state = ST_ACTIVE;
          w_qcnt  = '0;
          w_hcnt  = '0;
        end else w_qcnt = r_qcnt + QW'(1);
        ST_ACTIVE: if (w_s) w_hcnt = '0;
        else if (r_hcnt == HW'(HOLD_CYCLES - 1)) begin
          w_state = ST_BLANK;
          w_hcnt  = '0;
          w_bcnt  = '0;
        end else w_hcnt = r_hcnt + HW'(1);
        ST_BLANK: if (r_bcnt == BW'(BLANK_CYCLES - 1)) begin
          w_state = ST_IDLE;
          w_bcnt  = '0;
        end else w_bcnt = r_bcnt + BW'(1);
        default: w_state = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_state <= ST_IDLE;
      r_qcnt  <= '0;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
      r_pir   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_sensor_raw};
      r_state <= w_state;
      r_qcnt  <= w_qcnt;
      r_hcnt  <= w_hcnt;
      r_bcnt  <= w_bcnt;
      r_pir   <= (w_state == ST_ACTIVE);
    end
  end
`ifdef PIR_EVENT_COUNT_EN
  logic [CNT_W-1:0] r_evt;
  logic w_enter;
  assign w_enter       = (w_state == ST_ACTIVE) && (r_state != ST_ACTIVE);
  assign o_event_count = r_evt;
  // Clear has priority over a same-cycle detection; the count saturates.
  always_ff @(posedge clk) begin
    if (rst || i_clear_counts) r_evt <= '0;
    else if (w_enter && (r_evt != '1)) r_evt <= r_evt + CNT_W'(1);
  end
`endif
endmodule

// File: rtl/pir_sensor_conditioner.sv
// pir_sensor_conditioner: warm-up gating plus three independent PIR channel filters.
// Define PIR_EVENT_COUNT_EN to add clear_counts/event_count per-channel detection counters.
module pir_sensor_conditioner
  import pir_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int WARMUP_CYCLES = 200,
  parameter int QUAL_CYCLES   = 8,
  parameter int HOLD_CYCLES   = 20,
  parameter int BLANK_CYCLES  = 16,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_PIR-1:0]       sensor_raw,
`ifdef PIR_EVENT_COUNT_EN
  input  logic                     clear_counts,
  output logic [NUM_PIR*CNT_W-1:0] event_count,
`endif
  output logic [NUM_PIR-1:0]       pir_out,
  output logic                     motion_any,
  output logic                     warm_done
);
  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  logic [WW-1:0] r_warm_cnt;
  logic r_warm_done;
  logic r_motion_any;
  logic [NUM_PIR-1:0] w_pir_nxt;
  assign warm_done  = r_warm_done;
  assign motion_any = r_motion_any;
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_warm_cnt  <= '0;
      r_warm_done <= 1'b0;
    end else if (!r_warm_done) begin
      r_warm_cnt  <= r_warm_cnt + WW'(1);
      r_warm_done <= (r_warm_cnt == WW'(WARMUP_CYCLES - 1));
    end
  end
  // Built from the channels' next state so it switches on the same edge as pir_out.
  always_ff @(posedge clk) begin
    r_motion_any <= rst ? 1'b0 : |w_pir_nxt;
  end
  for (genvar g = 0; g < NUM_PIR; g++) begin : g_ch
    pir_channel_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .QUAL_CYCLES (QUAL_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .BLANK_CYCLES(BLANK_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .i_enable      (enable),
      .i_warm_done   (r_warm_done),
      .i_sensor_raw  (sensor_raw[g]),
`ifdef PIR_EVENT_COUNT_EN
      .i_clear_counts(clear_counts),
      .o_event_count (event_count[g*CNT_W +: CNT_W]),
`endif
      .o_pir         (pir_out[g]),
      .o_pir_nxt     (w_pir_nxt[g])
    );
  end
endmodule
